stream_engine: RTL

- Bus-side end of the main-memory stream port.
- Accepts a block-transfer command: direction, start address and word count.
  - Inbound: moves words from an external bus into main memory by driving stream_in, stream_address and stream_in_value.
  - Outbound: reads main memory through stream_out/stream_address and forwards the returned words to the external bus.
- Memory access happens only in cycles where the core grants the port, i.e. no instruction claims memory.

---
 rtl/stream_engine_if.sv | 55 +++++
 rtl/stream_engine.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/stream_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_engine_if
// Purpose  : Command, external bus and main-memory stream signals of the
//            stream engine, with host-side and engine-side views.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_engine_if #(
    parameter int WORD_WIDTH      = 32,
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int COUNT_WIDTH     = 16
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_dir;
    logic [MAIN_ADDR_WIDTH-1:0] cmd_address;
    logic [COUNT_WIDTH-1:0]     cmd_count;

    logic                       bus_in_valid;
    logic [WORD_WIDTH-1:0]      bus_in_data;
    logic                       bus_in_ready;

    logic                       bus_out_valid;
    logic [WORD_WIDTH-1:0]      bus_out_data;
    logic                       bus_out_ready;

    logic                       stream_in;
    logic [WORD_WIDTH-1:0]      stream_in_value;
    logic                       stream_out;
    logic [MAIN_ADDR_WIDTH-1:0] stream_address;
    logic                       stream_grant;
    logic [WORD_WIDTH-1:0]      main_read_value;

    logic                       busy;
    logic                       done;

    modport master (
        output cmd_valid, cmd_dir, cmd_address, cmd_count,
        output bus_in_valid, bus_in_data, bus_out_ready,
        output stream_grant, main_read_value,
        input  cmd_ready, bus_in_ready, bus_out_valid, bus_out_data,
        input  stream_in, stream_in_value, stream_out, stream_address,
        input  busy, done
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_address, cmd_count,
        input  bus_in_valid, bus_in_data, bus_out_ready,
        input  stream_grant, main_read_value,
        output cmd_ready, bus_in_ready, bus_out_valid, bus_out_data,
        output stream_in, stream_in_value, stream_out, stream_address,
        output busy, done
    );
endinterface
`default_nettype wire

// File: rtl/stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : stream_engine
// Purpose  : Block-transfer engine between an external word bus and the
//            main-memory stream port (inbound writes, outbound reads).
// Revision : 1.0 - initial release
// ============================================================================
module stream_engine #(
    parameter int WORD_WIDTH      = 32,
    parameter int MAIN_ADDR_WIDTH = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic           clk,
    input  logic           reset,
    stream_engine_if.slave bus
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_IN     = 2'd1;
    localparam logic [1:0] c_OUT    = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    localparam logic [MAIN_ADDR_WIDTH-1:0] c_ADDR_ONE = {{(MAIN_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0]     c_CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;
    logic [MAIN_ADDR_WIDTH-1:0] r_addr;
    logic [COUNT_WIDTH-1:0]     r_remaining;
    logic                       r_hold_valid;
    logic [WORD_WIDTH-1:0]      r_hold;
    logic [WORD_WIDTH-1:0]      r_fifo [2];
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic [1:0]                 r_fifo_count;
    logic                       r_inflight;

    logic       w_cmd_fire;
    logic       w_in_ready;
    logic       w_in_fire;
    logic       w_wr_grant;
    logic       w_rd_req;
    logic       w_rd_grant;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_occupancy;

    assign w_cmd_fire  = (r_state == c_IDLE) && bus.cmd_valid;
    assign w_in_ready  = (r_state == c_IN) && !r_hold_valid && (r_remaining != '0);
    assign w_in_fire   = w_in_ready && bus.bus_in_valid;
    assign w_wr_grant  = (r_state == c_IN) && r_hold_valid && bus.stream_grant;
    assign w_push      = r_inflight;
    assign w_pop       = (r_fifo_count != 2'd0) && bus.bus_out_ready;
    // A word leaving the FIFO this cycle frees its slot for a new read, which
    // is what allows one outbound word per cycle under continuous grant.
    assign w_occupancy = r_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_rd_req    = (r_state == c_OUT) && (r_remaining != '0) && (w_occupancy < 2'd2);
    assign w_rd_grant  = w_rd_req && bus.stream_grant;

    assign bus.bus_out_valid = (r_fifo_count != 2'd0);
    assign bus.bus_out_data  = (r_fifo_count != 2'd0) ? r_fifo[r_rd_ptr] : '0;

    always_comb begin
        w_state_next        = r_state;
        bus.cmd_ready       = 1'b0;
        bus.bus_in_ready    = 1'b0;
        bus.stream_in       = 1'b0;
        bus.stream_in_value = '0;
        bus.stream_out      = 1'b0;
        bus.stream_address  = '0;
        bus.busy            = 1'b1;
        bus.done            = 1'b0;
        case (r_state)
            c_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    if (bus.cmd_count == '0) begin
                        w_state_next = c_FINISH;
                    end else begin
                        w_state_next = bus.cmd_dir ? c_OUT : c_IN;
                    end
                end
            end
            c_IN: begin
                bus.bus_in_ready    = w_in_ready;
                bus.stream_in       = r_hold_valid;
                bus.stream_in_value = r_hold;
                bus.stream_address  = r_addr;
                if (w_wr_grant && (r_remaining == c_CNT_ONE)) begin
                    w_state_next = c_FINISH;
                end
            end
            c_OUT: begin
                bus.stream_out     = w_rd_req;
                bus.stream_address = r_addr;
                if ((r_remaining == '0) && !r_inflight && (r_fifo_count == 2'd0)) begin
                    w_state_next = c_FINISH;
                end
            end
            c_FINISH: begin
                bus.done     = 1'b1;
                w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_fifo_count <= 2'd0;
            r_inflight   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_cmd_fire) begin
                r_addr      <= bus.cmd_address;
                r_remaining <= bus.cmd_count;
            end
            if (w_in_fire) begin
                r_hold       <= bus.bus_in_data;
                r_hold_valid <= 1'b1;
            end
            if (w_wr_grant || w_rd_grant) begin
                r_addr      <= r_addr + c_ADDR_ONE;
                r_remaining <= r_remaining - c_CNT_ONE;
            end
            if (w_wr_grant) begin
                r_hold_valid <= 1'b0;
            end
            r_inflight   <= w_rd_grant;
            r_wr_ptr     <= r_wr_ptr ^ w_push;
            r_rd_ptr     <= r_rd_ptr ^ w_pop;
            r_fifo_count <= r_fifo_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Data storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.main_read_value;
        end
    end
endmodule
`default_nettype wire
